mips_mem_arbiter: RTL
=====================

// Module: mips_mem_arbiter
// PURPOSE
// Arbitrates the single-ported unified Mem between the pipeline's instruction-fetch
// port (IF) and data port (MEM stage LW/SW). One access per cycle; data side normally
// wins, with a streak limit so fetch is never starved. Sits between pipe_MIPS32 and Mem.
// PARAMETERS
// AW         10  word-address width (Mem depth = 2**AW words)
// DW         32  data width
// STREAK_MAX 4   max consecutive DM grants while IF waits; next grant goes to IF
// PORTS
// clk1       in   1   single clock, all state on posedge
// rst_n      in   1   asynchronous active-low reset
// halted     in   1   pipeline HALTED; 1 = IF requests never granted
// if_req     in   1   fetch request, held until if_gnt
// if_addr    in   AW  fetch word address
// if_gnt     out  1   fetch accepted this cycle (combinational)
// if_rvalid  out  1   if_rdata valid (cycle after if_gnt)
// if_rdata   out  DW  fetched instruction
// dm_req     in   1   data request, held until dm_gnt
// dm_we      in   1   1 = store (SW), 0 = load (LW)
// dm_addr    in   AW  data word address
// dm_wdata   in   DW  store data
// dm_gnt     out  1   data access accepted this cycle (combinational)
// dm_rvalid  out  1   load data valid (cycle after a load grant only)
// dm_rdata   out  DW  load data
// mem_en     out  1   Mem access strobe
// mem_we     out  1   Mem write enable
// mem_addr   out  AW  Mem address
// mem_wdata  out  DW  Mem write data
// mem_rdata  in   DW  Mem read data, 1-cycle latency after mem_en & !mem_we
// BEHAVIOUR
// - Reset (rst_n=0, async): if_rvalid=dm_rvalid=0, rsp_owner=NONE, streak=0;
//   if_rdata/dm_rdata=0. Grants/mem_* are combinational, forced 0 while rst_n=0.
// - Eligibility: if_ok = if_req & ~halted; dm_ok = dm_req.
// - Grant rule (same cycle as req): dm_ok & ~(if_ok & streak==STREAK_MAX) -> DM;
//   else if_ok -> IF; else none. At most one grant per cycle; mem_* mirror winner.
// - mem_en = if_gnt|dm_gnt; mem_we = dm_gnt&dm_we; mem_addr/wdata from winner, 0 idle.
// - streak (0..STREAK_MAX, saturating): +1 on DM grant while if_ok; cleared on IF grant
//   or when if_ok=0. Never exceeds STREAK_MAX.
// - Response FSM rsp_owner {NONE, IF, DM_RD}: next = IF on if_gnt, DM_RD on load
//   grant, NONE otherwise (incl. store). rvalid of owner asserted for exactly one cycle
//   with mem_rdata captured into that port's rdata; rdata holds until next response.
// - Latency: grant cycle N -> rvalid cycle N+1. Back-to-back grants allowed, full rate.
// - Store: no rvalid; Mem written at grant edge; load to same addr next cycle sees it.
// - Simultaneous if_ok & dm_ok, streak<MAX: DM granted, IF stalls (if_gnt=0).
// - halted=1 with if_req=1: no if_gnt, streak cleared; DM traffic unaffected.
// - halted rising while a fetch response is in flight: that if_rvalid still delivered.
// - Reset mid-access: in-flight response dropped; no rvalid after rst_n rises.
// - Requester must hold req/addr/we/wdata stable until gnt; arbiter does not latch.
// STRUCTURE
// - Shared package mips_mem_pkg: rsp_owner_t enum {RSP_NONE, RSP_IF, RSP_DM_RD},
//   MEM_AW=10, MEM_DW=32 constants, reused by pipe_MIPS32 and the bench.
// - One sub-module: mem_arb_streak_ctr (saturating streak counter + starvation flag).
// - Grant logic and response FSM stay inline in mips_mem_arbiter.
// TESTING
// 1. Reset: rst_n=0 with if_req=dm_req=1 -> all grants, rvalids, mem_en = 0.
// 2. IF only: if_req, if_addr=0, Mem[0]=32'h28010078 -> if_gnt same cycle,
//    if_rvalid next cycle with if_rdata=32'h28010078; 8 back-to-back fetches at full rate.
// 3. LW/SW: Mem[120]=85; load 120 -> dm_rvalid, dm_rdata=85; store 130 to addr 121
//    -> no dm_rvalid; load 121 next cycle -> 130.
// 4. Contention: if_req and dm_req held 10 cycles -> grants DM,DM,DM,DM,IF repeating
//    (STREAK_MAX=4); no cycle with both grants.
// 5. Halt: halted=1, if_req=1, dm_req pulses -> if_gnt never high, dm served every req;
//    fetch granted one cycle after halted=0 (halted raised after IF grant: rvalid still seen).
// 6. Reset mid-op: load granted, rst_n low before next edge -> no dm_rvalid after release.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the unified-memory path of pipe_MIPS32: memory
// geometry and the response-owner encoding used by the Mem arbiter.
// Reused by pipe_MIPS32, mips_mem_arbiter and its testbench.
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  localparam int MEM_AW = 10;  // word-address width, Mem depth = 2**MEM_AW
  localparam int MEM_DW = 32;  // data width

  // Who owns the Mem read data returning in the current cycle.
  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_IF    = 2'd1,
    RSP_DM_RD = 2'd2
  } rsp_owner_t;

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// ---------------------------------------------------------------------------
// mem_arb_streak_ctr
// Counts consecutive data-port grants made while a fetch is eligible and
// waiting. Saturates at STREAK_MAX; o_starve tells the arbiter that the
// next grant must go to the fetch port.
// Ports:
//   clk1      in   clock, all state on posedge
//   rst_n     in   asynchronous active-low reset
//   i_if_ok   in   fetch request eligible (if_req & ~halted)
//   i_if_gnt  in   fetch granted this cycle
//   i_dm_gnt  in   data port granted this cycle
//   o_streak  out  current streak count (0..STREAK_MAX)
//   o_starve  out  streak has reached STREAK_MAX
// ---------------------------------------------------------------------------
module mem_arb_streak_ctr #(
  parameter  int STREAK_MAX = 4,
  localparam int SW         = $clog2(STREAK_MAX + 1)
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          i_if_ok,
  input  logic          i_if_gnt,
  input  logic          i_dm_gnt,
  output logic [SW-1:0] o_streak,
  output logic          o_starve
);

  logic [SW-1:0] r_streak;
  logic          w_at_max;

  assign w_at_max = (r_streak == SW'(STREAK_MAX));

  // The streak only means something while a fetch is actually waiting, so it
  // restarts whenever the fetch side is served or drops out.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (!i_if_ok || i_if_gnt) begin
      r_streak <= '0;
    end else if (i_dm_gnt && !w_at_max) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  assign o_streak = r_streak;
  assign o_starve = w_at_max;

endmodule

// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
// Shares the single-ported unified Mem between the instruction-fetch port
// (IF) and the MEM-stage data port (LW/SW). One access per cycle; the data
// port wins by default, but after STREAK_MAX consecutive data grants with a
// fetch waiting, the fetch gets the next grant.
//
// Handshake: a requester raises *_req with stable address/we/wdata and holds
// them until *_gnt is seen high in the same cycle; gnt is combinational and
// the arbiter does not latch request fields. A granted read (any fetch, or a
// load) returns *_rvalid for exactly one cycle, the cycle after the grant;
// *_rdata holds that value until the next response to the same port. Stores
// have no response.
//
// Ports:
//   clk1, rst_n                      clock / async active-low reset
//   halted                           pipeline halted, blocks fetch grants
//   if_req/if_addr -> if_gnt         fetch request / grant
//   if_rvalid/if_rdata               fetch response
//   dm_req/dm_we/dm_addr/dm_wdata    data request
//   dm_gnt, dm_rvalid/dm_rdata       data grant / load response
//   mem_en/mem_we/mem_addr/mem_wdata Mem access (mirrors winner)
//   mem_rdata                        Mem read data, 1-cycle latency
//   dbg_rsp_owner, dbg_streak        response FSM state / streak count
// ---------------------------------------------------------------------------
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int STREAK_MAX = 4
) (
  input  logic                               clk1,
  input  logic                               rst_n,
  input  logic                               halted,
  input  logic                               if_req,
  input  logic [AW-1:0]                      if_addr,
  output logic                               if_gnt,
  output logic                               if_rvalid,
  output logic [DW-1:0]                      if_rdata,
  input  logic                               dm_req,
  input  logic                               dm_we,
  input  logic [AW-1:0]                      dm_addr,
  input  logic [DW-1:0]                      dm_wdata,
  output logic                               dm_gnt,
  output logic                               dm_rvalid,
  output logic [DW-1:0]                      dm_rdata,
  output logic                               mem_en,
  output logic                               mem_we,
  output logic [AW-1:0]                      mem_addr,
  output logic [DW-1:0]                      mem_wdata,
  input  logic [DW-1:0]                      mem_rdata,
  output rsp_owner_t                         dbg_rsp_owner,
  output logic [$clog2(STREAK_MAX+1)-1:0]    dbg_streak
);

  logic       w_if_ok;
  logic       w_starve;
  logic       w_dm_win;
  logic       w_if_win;
  rsp_owner_t r_rsp_owner;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;

  // ---- grant logic --------------------------------------------------------
  assign w_if_ok  = if_req & ~halted;
  assign w_dm_win = dm_req & ~(w_if_ok & w_starve);
  assign w_if_win = w_if_ok & ~w_dm_win;

  // Grants are combinational, so they must be masked while reset is held.
  assign dm_gnt = rst_n & w_dm_win;
  assign if_gnt = rst_n & w_if_win;

  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  mem_arb_streak_ctr #(
    .STREAK_MAX (STREAK_MAX)
  ) u_streak (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .i_if_ok  (w_if_ok),
    .i_if_gnt (if_gnt),
    .i_dm_gnt (dm_gnt),
    .o_streak (dbg_streak),
    .o_starve (w_starve)
  );

  // ---- response FSM -------------------------------------------------------
  // r_rsp_owner names the port whose read data Mem presents this cycle. The
  // live mem_rdata is forwarded during the response cycle and captured at its
  // end so rdata holds until the next response. Reset drops any response in
  // flight because the owner returns to RSP_NONE.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_owner <= RSP_NONE;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      case (r_rsp_owner)
        RSP_IF:    r_if_rdata <= mem_rdata;
        RSP_DM_RD: r_dm_rdata <= mem_rdata;
        default:   ;
      endcase
      if (if_gnt) begin
        r_rsp_owner <= RSP_IF;
      end else if (dm_gnt && !dm_we) begin
        r_rsp_owner <= RSP_DM_RD;
      end else begin
        r_rsp_owner <= RSP_NONE;
      end
    end
  end

  assign if_rvalid     = (r_rsp_owner == RSP_IF);
  assign dm_rvalid     = (r_rsp_owner == RSP_DM_RD);
  assign if_rdata      = if_rvalid ? mem_rdata : r_if_rdata;
  assign dm_rdata      = dm_rvalid ? mem_rdata : r_dm_rdata;
  assign dbg_rsp_owner = r_rsp_owner;

endmodule
